// File: rtl/proc_pkg.sv
// Shared definitions for the convolution processor: field widths, opcode
// constants used by the fetch and control units, and the fetch state encoding.
package proc_pkg;

    localparam int unsigned INSTR_W  = 16;
    localparam int unsigned OPC_W    = 6;
    localparam int unsigned IMM_W    = 10;
    localparam int unsigned ADDR_W   = 8;
    localparam int unsigned PROG_LEN = 164;

    localparam logic [OPC_W-1:0] OP_CLAC   = 6'd2;
    localparam logic [OPC_W-1:0] OP_NOP    = 6'd46;
    localparam logic [OPC_W-1:0] OP_JUMPNZ = 6'd47;
    localparam logic [OPC_W-1:0] OP_JUMPZ  = 6'd51;

    typedef enum logic [2:0] {
        FS_IDLE  = 3'd0,
        FS_FETCH = 3'd1,
        FS_WAIT  = 3'd2,
        FS_ISSUE = 3'd3,
        FS_HALT  = 3'd4
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus: instruction RAM address/data plus the control-unit handshake.
//   pc_addr     : word address to the synchronous instruction RAM
//   instr_in    : registered RAM data, valid one cycle after pc_addr
//   exec_done   : control unit finished the current instruction (pulse)
//   z_flag      : accumulator-zero flag, meaningful with exec_done
//   opcode/imm  : decoded fields of the instruction register
//   instr_valid : opcode/imm are stable and awaiting execution
// master = fetch unit, slave = RAM/control-unit side.
interface instr_fetch_unit_if;
    import proc_pkg::*;

    logic [ADDR_W-1:0]  pc_addr;
    logic [INSTR_W-1:0] instr_in;
    logic               exec_done;
    logic               z_flag;
    logic [OPC_W-1:0]   opcode;
    logic [IMM_W-1:0]   imm;
    logic               instr_valid;

    modport master (
        output pc_addr, opcode, imm, instr_valid,
        input  instr_in, exec_done, z_flag
    );

    modport slave (
        input  pc_addr, opcode, imm, instr_valid,
        output instr_in, exec_done, z_flag
    );

endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction-fetch initiator: sequences FETCH/WAIT/ISSUE against a synchronous
// instruction RAM, holds the instruction register for the control unit,
// resolves conditional jumps, stops on NOP and flags out-of-range PCs.
// Ports:
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   start      : begin fetching at address 0 from IDLE or HALT
//   bus        : RAM address/data and control-unit handshake (master side)
//   halted     : high while in HALT
//   pc_err     : sticky, PC reached an address >= PROG_LEN
module instr_fetch_unit
    import proc_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    instr_fetch_unit_if.master  bus,
    output logic                halted,
    output logic                pc_err
);

    fetch_state_t        r_state;
    fetch_state_t        w_state_nxt;

    logic [ADDR_W-1:0]   r_pc;
    logic [INSTR_W-1:0]  r_ir;
    logic                r_valid;
    logic                r_halted;
    logic                r_pc_err;

    logic [ADDR_W-1:0]   w_pc_nxt;
    logic [INSTR_W-1:0]  w_ir_nxt;
    logic                w_valid_nxt;
    logic                w_halted_nxt;
    logic                w_pc_err_nxt;

    logic [OPC_W-1:0]    w_opc;
    logic [IMM_W-1:0]    w_imm;
    logic                w_taken;
    logic [ADDR_W-1:0]   w_target;
    logic                w_target_bad;

    assign w_opc = r_ir[INSTR_W-1:IMM_W];
    assign w_imm = r_ir[IMM_W-1:0];

    // Next-PC selection; only consumed when exec_done arrives in ISSUE.
    assign w_taken      = ((w_opc == OP_JUMPZ)  &&  bus.z_flag) ||
                          ((w_opc == OP_JUMPNZ) && !bus.z_flag);
    assign w_target     = w_taken ? w_imm[ADDR_W-1:0] : (r_pc + ADDR_W'(1));
    assign w_target_bad = (w_target >= ADDR_W'(PROG_LEN));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FS_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and next-datapath values.
    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_ir_nxt     = r_ir;
        w_valid_nxt  = r_valid;
        w_halted_nxt = r_halted;
        w_pc_err_nxt = r_pc_err;

        case (r_state)
            FS_IDLE: begin
                if (start) begin
                    w_pc_nxt    = '0;
                    w_state_nxt = FS_FETCH;
                end
            end
            FS_FETCH: begin
                w_state_nxt = FS_WAIT;
            end
            FS_WAIT: begin
                w_ir_nxt    = bus.instr_in;
                w_valid_nxt = 1'b1;
                w_state_nxt = FS_ISSUE;
            end
            FS_ISSUE: begin
                if (bus.exec_done) begin
                    w_valid_nxt = 1'b0;
                    if (w_opc == OP_NOP) begin
                        w_halted_nxt = 1'b1;
                        w_state_nxt  = FS_HALT;
                    end else begin
                        w_pc_nxt = w_target;
                        // An illegal PC never reaches FETCH.
                        if (w_target_bad) begin
                            w_pc_err_nxt = 1'b1;
                            w_halted_nxt = 1'b1;
                            w_state_nxt  = FS_HALT;
                        end else begin
                            w_state_nxt  = FS_FETCH;
                        end
                    end
                end
            end
            FS_HALT: begin
                if (start) begin
                    w_pc_nxt     = '0;
                    w_pc_err_nxt = 1'b0;
                    w_halted_nxt = 1'b0;
                    w_state_nxt  = FS_FETCH;
                end
            end
            default: begin
                w_state_nxt = FS_IDLE;
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc     <= '0;
            r_ir     <= '0;
            r_valid  <= 1'b0;
            r_halted <= 1'b0;
            r_pc_err <= 1'b0;
        end else begin
            r_pc     <= w_pc_nxt;
            r_ir     <= w_ir_nxt;
            r_valid  <= w_valid_nxt;
            r_halted <= w_halted_nxt;
            r_pc_err <= w_pc_err_nxt;
        end
    end

    assign bus.pc_addr     = r_pc;
    assign bus.opcode      = w_opc;
    assign bus.imm         = w_imm;
    assign bus.instr_valid = r_valid;
    assign halted          = r_halted;
    assign pc_err          = r_pc_err;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a synchronous RAM model, a table of
// program steps (expected PC/opcode/imm, z_flag, stall length) and hand-written
// halt, restart and asynchronous-reset sequences.
module tb_instr_fetch_unit;
    import proc_pkg::*;

    typedef struct {
        logic [7:0] pc;
        logic [5:0] opc;
        logic [9:0] imm;
        logic       z;
        int         hold;
        logic       wait_pulse;
        logic       start_in_issue;
        logic       halt_after;
        logic       err_after;
    } step_t;

    localparam int NSTEP = 14;

    logic clk;
    logic rst_n;
    logic start;
    logic halted;
    logic pc_err;

    logic [15:0] mem [0:255];
    step_t       tab [NSTEP];

    int n_checks;
    int n_fail;

    instr_fetch_unit_if bus();

    instr_fetch_unit dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .bus    (bus.master),
        .halted (halted),
        .pc_err (pc_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous instruction RAM: data appears the cycle after the address.
    always_ff @(posedge clk) bus.instr_in <= mem[bus.pc_addr];

    function automatic logic [15:0] enc(input logic [5:0] opc, input logic [9:0] imm);
        return {opc, imm};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Entered at the falling edge right after the FETCH state was entered.
    task automatic run_step(input step_t s);
        chk("fetch_pc_addr", 32'(bus.pc_addr), 32'(s.pc));
        chk("fetch_valid", 32'(bus.instr_valid), 0);
        chk("fetch_halted", 32'(halted), 0);
        chk("fetch_pc_err", 32'(pc_err), 0);
        if (s.wait_pulse) begin
            bus.exec_done = 1'b1;
            bus.z_flag    = ~s.z;
        end
        @(negedge clk);
        bus.exec_done = 1'b0;
        bus.z_flag    = 1'b0;
        chk("wait_valid", 32'(bus.instr_valid), 0);
        @(negedge clk);
        chk("issue_valid", 32'(bus.instr_valid), 1);
        chk("issue_opcode", 32'(bus.opcode), 32'(s.opc));
        chk("issue_imm", 32'(bus.imm), 32'(s.imm));
        chk("issue_pc_addr", 32'(bus.pc_addr), 32'(s.pc));
        for (int h = 0; h < s.hold; h++) begin
            start = s.start_in_issue;
            @(negedge clk);
            start = 1'b0;
            chk("stall_valid", 32'(bus.instr_valid), 1);
            chk("stall_opcode", 32'(bus.opcode), 32'(s.opc));
            chk("stall_imm", 32'(bus.imm), 32'(s.imm));
            chk("stall_pc_addr", 32'(bus.pc_addr), 32'(s.pc));
        end
        bus.exec_done = 1'b1;
        bus.z_flag    = s.z;
        @(negedge clk);
        bus.exec_done = 1'b0;
        bus.z_flag    = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n         = 1'b0;
        start         = 1'b0;
        bus.exec_done = 1'b0;
        bus.z_flag    = 1'b0;

        for (int a = 0; a < 256; a++) mem[a] = enc(OP_CLAC, 10'd0);
        mem[0]   = enc(OP_CLAC,   10'd0);
        mem[1]   = enc(OP_JUMPZ,  10'd142);
        mem[142] = enc(OP_JUMPZ,  10'd159);
        mem[159] = enc(OP_JUMPNZ, 10'd142);
        mem[143] = enc(OP_JUMPNZ, 10'd162);
        mem[162] = enc(OP_JUMPNZ, 10'd63);
        mem[63]  = enc(OP_JUMPZ,  10'd162);
        mem[163] = enc(OP_NOP,    10'd0);
        mem[5]   = enc(OP_JUMPNZ, 10'd200);

        //            pc      opc        imm      z    hold wpulse stIss halt err
        tab[0]  = '{8'd0,   OP_CLAC,   10'd0,   1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0};
        tab[1]  = '{8'd1,   OP_JUMPZ,  10'd142, 1'b1, 0, 1'b1, 1'b0, 1'b0, 1'b0};
        tab[2]  = '{8'd142, OP_JUMPZ,  10'd159, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0};
        tab[3]  = '{8'd159, OP_JUMPNZ, 10'd142, 1'b0, 10, 1'b0, 1'b1, 1'b0, 1'b0};
        tab[4]  = '{8'd142, OP_JUMPZ,  10'd159, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0};
        tab[5]  = '{8'd143, OP_JUMPNZ, 10'd162, 1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b0};
        tab[6]  = '{8'd162, OP_JUMPNZ, 10'd63,  1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0};
        tab[7]  = '{8'd63,  OP_JUMPZ,  10'd162, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0};
        tab[8]  = '{8'd162, OP_JUMPNZ, 10'd63,  1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0};
        tab[9]  = '{8'd163, OP_NOP,    10'd0,   1'b0, 1, 1'b0, 1'b0, 1'b1, 1'b0};
        tab[10] = '{8'd0,   OP_CLAC,   10'd0,   1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0};
        tab[11] = '{8'd1,   OP_JUMPZ,  10'h305, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0};
        tab[12] = '{8'd5,   OP_JUMPNZ, 10'd200, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b1};
        tab[13] = '{8'd0,   OP_CLAC,   10'd0,   1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0};

        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst_pc_addr", 32'(bus.pc_addr), 0);
        chk("rst_opcode", 32'(bus.opcode), 0);
        chk("rst_imm", 32'(bus.imm), 0);
        chk("rst_valid", 32'(bus.instr_valid), 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_pc_err", 32'(pc_err), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_valid", 32'(bus.instr_valid), 0);
        chk("idle_pc_addr", 32'(bus.pc_addr), 0);

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;

        for (int i = 0; i < NSTEP; i++) begin
            run_step(tab[i]);
            if (tab[i].halt_after) begin
                chk("halt_halted", 32'(halted), 1);
                chk("halt_pc_err", 32'(pc_err), 32'(tab[i].err_after));
                chk("halt_valid", 32'(bus.instr_valid), 0);
                if (!tab[i].err_after)
                    chk("halt_pc_hold", 32'(bus.pc_addr), 32'(tab[i].pc));
                for (int c = 0; c < 3; c++) begin
                    @(negedge clk);
                    chk("halt_stay_valid", 32'(bus.instr_valid), 0);
                    chk("halt_stay_halted", 32'(halted), 1);
                end
                if (i == 9) begin
                    mem[1] = enc(OP_JUMPZ, 10'h305);
                end
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        end

        // Asynchronous reset in the middle of ISSUE.
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_valid", 32'(bus.instr_valid), 1);
        chk("pre_rst_opcode", 32'(bus.opcode), 32'(OP_JUMPZ));
        #2 rst_n = 1'b0;
        #1;
        chk("arst_pc_addr", 32'(bus.pc_addr), 0);
        chk("arst_opcode", 32'(bus.opcode), 0);
        chk("arst_imm", 32'(bus.imm), 0);
        chk("arst_valid", 32'(bus.instr_valid), 0);
        chk("arst_halted", 32'(halted), 0);
        chk("arst_pc_err", 32'(pc_err), 0);
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("post_rst_valid", 32'(bus.instr_valid), 0);
            chk("post_rst_pc_addr", 32'(bus.pc_addr), 0);
            chk("post_rst_halted", 32'(halted), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
